mutex_rule_scheduler: RTL and testbench
=======================================

// Module: mutex_rule_scheduler
// PURPOSE
//   Round-robin rule scheduler driving the per-node rule-enable vector io_en_a of the generated
//   mutual-exclusion system (NODES x 2-bit node state, 1-bit exclusive flag).
//   Fires at most one enabled node rule per decision, then waits one settle cycle for the
//   system state registers to update. Tracks per-node waiting to flag starvation.
// PARAMETERS
//   NODES        3   number of node rule instances (width of io_en_a)
//   STARVE_LIMIT 7   losing decisions before a requester is flagged starved (>=1)
//   CNT_W        16  width of fire counter
// PORTS
//   clock        in   1            system clock, rising edge
//   reset        in   1            asynchronous, active-low reset
//   io_req       in   NODES        per-node rule guard true (rule would change state if fired)
//   io_hold      in   1            stall: no new decision while high
//   io_en_a      out  NODES        one-hot rule enable to system, high for exactly 1 cycle
//   io_busy      out  1            high in ISSUE or SETTLE
//   io_grant_idx out  clog2(NODES) index of last fired node
//   io_fire_cnt  out  CNT_W        number of rules fired, wraps
//   io_starve    out  1            sticky starvation flag
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, ptr=0, io_en_a=0, io_busy=0, io_grant_idx=0,
//     io_fire_cnt=0, io_starve=0, all wait counters=0. Outputs are registered.
//   FSM IDLE -> ISSUE -> SETTLE -> IDLE:
//     IDLE: if io_hold==0 and io_req!=0: pick winner = first set bit of io_req scanning
//       ptr, ptr+1, ... mod NODES; register grant; go ISSUE. Otherwise stay in IDLE.
//     ISSUE (1 cycle): io_en_a = 1<<grant, io_busy=1; ptr <= (grant+1) mod NODES;
//       io_grant_idx <= grant; io_fire_cnt <= io_fire_cnt+1 (wraps at 2^CNT_W). Go SETTLE.
//     SETTLE (1 cycle): io_en_a=0, io_busy=1; guards re-evaluate; go IDLE.
//   Latency: io_req sampled in IDLE at edge t -> io_en_a high during cycle t+1. Minimum
//     spacing between fires is 3 cycles. io_en_a is never multi-hot and never high in IDLE
//     or SETTLE.
//   io_hold or io_req changes while in ISSUE/SETTLE are ignored; the registered grant fires
//     unchanged, because the system re-checks its own guard.
//   Winner selection uses the registered ptr only; ptr moves only on a fire.
//   Starvation: at each ISSUE, every node i != grant with io_req[i]==1 has wait[i]
//     incremented (saturates at STARVE_LIMIT). The granted node's wait clears. Any node with
//     io_req[i]==0 in IDLE has its wait cleared. If any wait[i]==STARVE_LIMIT, io_starve <= 1.
//     The flag stays set until reset.
//   Reset mid-ISSUE: io_en_a drops to 0 immediately (async). No partial fire is counted.
//   NODES not a power of two: ptr wraps from NODES-1 to 0; index values >= NODES never occur.
// TESTING
//   T1 reset: reset=0 for 2 cycles, io_req=3'b111 -> io_en_a=0, io_fire_cnt=0,
//      io_starve=0 throughout.
//   T2 single request: io_req=3'b001 held -> io_en_a=001 every 3rd cycle, first one cycle
//      after the IDLE sample; io_fire_cnt=3 after 9 cycles.
//   T3 round-robin: io_req=3'b111 held -> io_en_a sequence 001,010,100,001;
//      io_grant_idx 0,1,2,0.
//   T4 skip: ptr=1, io_req=3'b101 -> fires 100, then 001; ptr ends at 1.
//   T5 hold: io_hold=1 with io_req=3'b010 for 5 cycles -> io_en_a=0, io_busy=0. Release ->
//      io_en_a=010 one cycle later.
//   T6 starvation/reset: force STARVE_LIMIT=1, ptr=0, io_req=3'b011 -> after the node-0 fire
//      io_starve=1 (sticky). Assert reset during ISSUE -> io_en_a=0 that cycle, io_starve=0,
//      io_fire_cnt=0.

Source files
------------

// File: rtl/mutex_rule_scheduler.sv
// mutex_rule_scheduler
//   Round-robin rule scheduler for the generated mutual-exclusion system.
//   It fires at most one enabled node rule per decision. After each fire it
//   waits one settle cycle so the system state registers can update before
//   the guards are sampled again. It also tracks how long each requester has
//   waited, so that starvation can be flagged.
//
// Ports
//   clock        in   1        system clock, rising edge
//   reset        in   1        asynchronous, active-low reset
//   io_req       in   NODES    per-node rule guard is true
//   io_hold      in   1        stall: no new decision while high
//   io_en_a      out  NODES    one-hot rule enable, high for exactly one cycle
//   io_busy      out  1        high while in ISSUE or SETTLE
//   io_grant_idx out  IDX_W    index of the last fired node
//   io_fire_cnt  out  CNT_W    number of rules fired (wraps)
//   io_starve    out  1        sticky starvation flag
module mutex_rule_scheduler #(
    parameter int NODES        = 3,
    parameter int STARVE_LIMIT = 7,
    parameter int CNT_W        = 16,
    localparam int IDX_W       = (NODES > 1) ? $clog2(NODES) : 1,
    localparam int WAIT_W      = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NODES-1:0] io_req,
    input  logic             io_hold,
    output logic [NODES-1:0] io_en_a,
    output logic             io_busy,
    output logic [IDX_W-1:0] io_grant_idx,
    output logic [CNT_W-1:0] io_fire_cnt,
    output logic             io_starve
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  winner;
    logic              found;
    logic [IDX_W-1:0]  ptr_next;
    logic              wait_hit;
    logic [WAIT_W-1:0] wait_cnt [NODES];

    // The winner is found by scanning the requests circularly, starting at
    // the registered pointer. The pointer moves only when a rule fires, so
    // the winner cannot change while a fire is in flight.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NODES; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NODES) idx = idx - NODES;
            if (!found && io_req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    // NODES need not be a power of two, so the pointer wraps explicitly
    // from NODES-1 back to 0.
    always_comb begin
        ptr_next = grant + IDX_W'(1);
        if (int'(grant) == NODES - 1) ptr_next = '0;
    end

    // The starvation check looks at the registered wait counters. The flag
    // therefore rises on the edge after a counter reaches the limit.
    always_comb begin
        wait_hit = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            if (wait_cnt[i] == WAIT_W'(STARVE_LIMIT)) wait_hit = 1'b1;
        end
    end

    // The state register is kept in its own process.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic. A decision is made only in IDLE. ISSUE and SETTLE
    // always last exactly one cycle each.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!io_hold && found) next_state = ISSUE;
            ISSUE:   next_state = SETTLE;
            SETTLE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs and bookkeeping. The enable is loaded on the IDLE
    // decision edge, so it is high for exactly the ISSUE cycle. The fire
    // count is committed only on the edge that leaves ISSUE. As a result, a
    // reset that arrives during ISSUE never counts a partial fire.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr          <= '0;
            grant        <= '0;
            io_en_a      <= '0;
            io_busy      <= 1'b0;
            io_grant_idx <= '0;
            io_fire_cnt  <= '0;
            io_starve    <= 1'b0;
            for (int i = 0; i < NODES; i++) wait_cnt[i] <= '0;
        end else begin
            if (wait_hit) io_starve <= 1'b1;
            case (state)
                IDLE: begin
                    for (int i = 0; i < NODES; i++) begin
                        if (!io_req[i]) wait_cnt[i] <= '0;
                    end
                    if (!io_hold && found) begin
                        grant   <= winner;
                        io_en_a <= NODES'(1) << winner;
                        io_busy <= 1'b1;
                    end
                end
                ISSUE: begin
                    io_en_a      <= '0;
                    ptr          <= ptr_next;
                    io_grant_idx <= grant;
                    io_fire_cnt  <= io_fire_cnt + CNT_W'(1);
                    for (int i = 0; i < NODES; i++) begin
                        if (IDX_W'(i) == grant) begin
                            wait_cnt[i] <= '0;
                        end else if (io_req[i] && (wait_cnt[i] < WAIT_W'(STARVE_LIMIT))) begin
                            wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
                        end
                    end
                end
                SETTLE: begin
                    io_en_a <= '0;
                    io_busy <= 1'b0;
                end
                default: begin
                    io_en_a <= '0;
                    io_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mutex_rule_scheduler.sv
// tb_mutex_rule_scheduler
//   Directed bench for mutex_rule_scheduler. The main instance uses the
//   default parameters. A second instance with STARVE_LIMIT=1 shares the
//   same inputs, so that starvation can be provoked with a short sequence.
//   Inputs change 1 time unit after a rising edge. Outputs are sampled at
//   the same point.
module tb_mutex_rule_scheduler;

    logic        clock;
    logic        reset;
    logic [2:0]  io_req;
    logic        io_hold;
    logic [2:0]  io_en_a;
    logic        io_busy;
    logic [1:0]  io_grant_idx;
    logic [15:0] io_fire_cnt;
    logic        io_starve;

    logic [2:0]  s_en_a;
    logic        s_busy;
    logic [1:0]  s_grant_idx;
    logic [15:0] s_fire_cnt;
    logic        s_starve;

    int vectors     = 0;
    int miscompares = 0;

    mutex_rule_scheduler #(.NODES(3), .STARVE_LIMIT(7), .CNT_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_req       (io_req),
        .io_hold      (io_hold),
        .io_en_a      (io_en_a),
        .io_busy      (io_busy),
        .io_grant_idx (io_grant_idx),
        .io_fire_cnt  (io_fire_cnt),
        .io_starve    (io_starve)
    );

    mutex_rule_scheduler #(.NODES(3), .STARVE_LIMIT(1), .CNT_W(16)) dut_s (
        .clock        (clock),
        .reset        (reset),
        .io_req       (io_req),
        .io_hold      (io_hold),
        .io_en_a      (s_en_a),
        .io_busy      (s_busy),
        .io_grant_idx (s_grant_idx),
        .io_fire_cnt  (s_fire_cnt),
        .io_starve    (s_starve)
    );

    // 10-unit clock period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic apply_stimulus(input logic [2:0] req, input logic hold, input logic rst_n);
        io_req  = req;
        io_hold = hold;
        reset   = rst_n;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [2:0] rr_en  [4];
        logic [1:0] rr_idx [4];
        rr_en  = '{3'b001, 3'b010, 3'b100, 3'b001};
        rr_idx = '{2'd0, 2'd1, 2'd2, 2'd0};

        // T1: reset is held low while every guard is true.
        apply_stimulus(3'b111, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_output("t1_en_async", 32'(io_en_a), 32'h0);
        for (int c = 0; c < 2; c++) begin
            tick(1);
            check_output("t1_en", 32'(io_en_a), 32'h0);
            check_output("t1_cnt", 32'(io_fire_cnt), 32'h0);
            check_output("t1_starve", 32'(io_starve), 32'h0);
            check_output("t1_busy", 32'(io_busy), 32'h0);
        end

        // T2: a single steady requester fires every third cycle.
        apply_stimulus(3'b001, 1'b0, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            check_output("t2_en", 32'(io_en_a), (k % 3 == 1) ? 32'h1 : 32'h0);
            check_output("t2_busy", 32'(io_busy), (k % 3 != 0) ? 32'h1 : 32'h0);
        end
        check_output("t2_cnt", 32'(io_fire_cnt), 32'd3);

        // Reset again so that the round-robin test starts from ptr=0.
        apply_stimulus(3'b000, 1'b0, 1'b0);
        tick(1);
        check_output("rst_cnt", 32'(io_fire_cnt), 32'd0);
        apply_stimulus(3'b111, 1'b0, 1'b1);

        // T3: all three nodes request and fire in rotation.
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (k % 3 == 1) check_output("t3_en", 32'(io_en_a), 32'(rr_en[(k - 1) / 3]));
            else            check_output("t3_en_idle", 32'(io_en_a), 32'h0);
            if (k % 3 == 2) check_output("t3_gidx", 32'(io_grant_idx), 32'(rr_idx[(k - 2) / 3]));
        end

        // T4: with ptr=1 and requests on nodes 0 and 2, node 1 is skipped.
        apply_stimulus(3'b101, 1'b0, 1'b1);
        tick(1);
        check_output("t4_en_first", 32'(io_en_a), 32'b100);
        tick(1);
        check_output("t4_gidx_first", 32'(io_grant_idx), 32'd2);
        tick(2);
        check_output("t4_en_second", 32'(io_en_a), 32'b001);
        tick(1);
        check_output("t4_gidx_second", 32'(io_grant_idx), 32'd0);
        tick(1);
        apply_stimulus(3'b111, 1'b0, 1'b1);
        tick(1);
        check_output("t4_ptr_is_1", 32'(io_en_a), 32'b010);
        // Dropping the request during ISSUE must not cancel the fire.
        apply_stimulus(3'b000, 1'b0, 1'b1);
        tick(1);
        check_output("t4_gidx_third", 32'(io_grant_idx), 32'd1);
        check_output("t4_cnt", 32'(io_fire_cnt), 32'd7);
        tick(1);
        check_output("t4_starve", 32'(io_starve), 32'h0);

        // T5: io_hold stalls the decision until it is released.
        apply_stimulus(3'b010, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check_output("t5_en_hold", 32'(io_en_a), 32'h0);
            check_output("t5_busy_hold", 32'(io_busy), 32'h0);
        end
        apply_stimulus(3'b010, 1'b0, 1'b1);
        tick(1);
        check_output("t5_en_release", 32'(io_en_a), 32'b010);
        apply_stimulus(3'b000, 1'b0, 1'b1);
        tick(2);
        check_output("t5_cnt", 32'(io_fire_cnt), 32'd8);

        // T6: starvation with STARVE_LIMIT=1, then a reset during ISSUE.
        apply_stimulus(3'b000, 1'b0, 1'b0);
        #1;
        check_output("t6_rst_cnt", 32'(io_fire_cnt), 32'd0);
        tick(1);
        apply_stimulus(3'b011, 1'b0, 1'b1);
        tick(1);
        check_output("t6_s_en_node0", 32'(s_en_a), 32'b001);
        tick(2);
        check_output("t6_s_starve_set", 32'(s_starve), 32'h1);
        tick(1);
        check_output("t6_en_node1", 32'(io_en_a), 32'b010);
        tick(2);
        check_output("t6_s_starve_sticky", 32'(s_starve), 32'h1);
        check_output("t6_main_no_starve", 32'(io_starve), 32'h0);
        tick(1);
        check_output("t6_en_node0_again", 32'(io_en_a), 32'b001);
        reset = 1'b0;
        #1;
        check_output("t6_en_mid_reset", 32'(io_en_a), 32'h0);
        check_output("t6_s_en_mid_reset", 32'(s_en_a), 32'h0);
        check_output("t6_s_starve_reset", 32'(s_starve), 32'h0);
        check_output("t6_cnt_reset", 32'(io_fire_cnt), 32'd0);
        check_output("t6_busy_reset", 32'(io_busy), 32'h0);
        tick(1);
        apply_stimulus(3'b000, 1'b0, 1'b1);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
